mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs (me_alu_o, me_regs_data2, me_mem_read, me_mem_write, me_func3_code).
- Converts each load/store into a request/grant/response transaction on the data-memory bus, with byte-lane steering, load sign/zero extension and misalignment detection.
- Stalls the pipeline with mem_stall until the access completes.
- Upstream holds the me_* inputs stable while mem_stall=1.

---
 rtl/mem_access_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ----------------
// MEM-stage load/store engine. Takes the EX/MEM register outputs and turns
// each load or store into a request/grant/response transaction on the
// data-memory bus. It also steers store data onto byte lanes, sign- or
// zero-extends load data, flags misaligned accesses and times out a
// transaction that never completes.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   flush               kill the current MEM-stage access
//   me_alu_o            effective byte address
//   me_regs_data2       store data
//   me_mem_read/write   load / store request (both high = load)
//   me_func3_code       size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   dm_req/we/addr/be/wdata   bus request side
//   dm_gnt/rvalid/rdata       bus grant and response side
//   mem_stall           freeze IF..EX/MEM while the access is in flight
//   mem_load_data       extended load result (held until the next capture)
//   mem_load_valid      one-cycle pulse, load result valid
//   mem_misalign        misaligned access detected (combinational)
//   bus_err             one-cycle pulse on timeout
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [2:0]  me_func3_code,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_load_q;
  logic             unsigned_q;
  logic             kill_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             dm_we_q;
  logic [31:0]      dm_addr_q;
  logic [3:0]       dm_be_q;
  logic [31:0]      dm_wdata_q;
  logic [31:0]      load_data_q;
  logic             load_valid_q;
  logic             bus_err_q;

  // Request decode from the EX/MEM register.
  logic        acc;
  logic [1:0]  size_in;
  logic        misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    acc = me_mem_read | me_mem_write;
    case (me_func3_code[1:0])
      2'b00:   size_in = SZ_B;
      2'b01:   size_in = SZ_H;
      default: size_in = SZ_W;   // 010 plus the unused 011/110/111
    endcase
    misaligned = ((size_in == SZ_H) && me_alu_o[0]) ||
                 ((size_in == SZ_W) && (me_alu_o[1:0] != 2'b00));
    // Loads read the whole word; stores replicate data across the lanes so
    // the byte enables alone pick the target bytes.
    be_in    = 4'b1111;
    wdata_in = 32'h0;
    if (!me_mem_read) begin
      case (size_in)
        SZ_B: begin
          be_in    = 4'b0001 << me_alu_o[1:0];
          wdata_in = {4{me_regs_data2[7:0]}};
        end
        SZ_H: begin
          be_in    = me_alu_o[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{me_regs_data2[15:0]}};
        end
        default: begin
          be_in    = 4'b1111;
          wdata_in = me_regs_data2;
        end
      endcase
    end
  end

  // Load extraction uses the offset/size captured at request time, because
  // the returning word may arrive after upstream values stop mattering.
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_ext;

  always_comb begin
    case (off_q)
      2'd0:    rbyte = dm_rdata[7:0];
      2'd1:    rbyte = dm_rdata[15:8];
      2'd2:    rbyte = dm_rdata[23:16];
      default: rbyte = dm_rdata[31:24];
    endcase
    rhalf = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      SZ_B:    load_ext = unsigned_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      SZ_H:    load_ext = unsigned_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_ext = dm_rdata;
    endcase
  end

  // The access is abandoned on the cycle the counter would reach the limit,
  // so at most TIMEOUT_CYC cycles are spent in REQ+WAIT.
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      unsigned_q   <= 1'b0;
      kill_q       <= 1'b0;
      size_q       <= SZ_B;
      off_q        <= 2'd0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= 32'h0;
      dm_be_q      <= 4'h0;
      dm_wdata_q   <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc && !misaligned && !flush) begin
            is_load_q  <= me_mem_read;
            unsigned_q <= me_func3_code[2];
            size_q     <= size_in;
            off_q      <= me_alu_o[1:0];
            dm_we_q    <= me_mem_write & ~me_mem_read;
            dm_addr_q  <= {me_alu_o[31:2], 2'b00};
            dm_be_q    <= be_in;
            dm_wdata_q <= wdata_in;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_inc;
          if (dm_gnt) begin
            // Once granted the transaction is outstanding; a simultaneous
            // flush only suppresses the load result.
            kill_q  <= flush;
            state_q <= is_load_q ? S_WAIT : S_DONE;
          end else if (flush) begin
            state_q <= S_IDLE;
          end else if (timeout) begin
            bus_err_q   <= 1'b1;
            load_data_q <= 32'h0;
            state_q     <= S_DONE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_inc;
          if (flush) begin
            kill_q <= 1'b1;
          end
          if (dm_rvalid) begin
            if (kill_q || flush) begin
              state_q <= S_IDLE;
            end else begin
              load_data_q  <= load_ext;
              load_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end
          end else if (timeout) begin
            bus_err_q   <= 1'b1;
            load_data_q <= 32'h0;
            state_q     <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall covers the IDLE cycle in which an aligned access is accepted, so
  // the pipeline holds the instruction until DONE.
  assign mem_stall = ~rst & (((state_q == S_IDLE) & acc & ~misaligned & ~flush) |
                             (state_q == S_REQ) | (state_q == S_WAIT));
  assign mem_misalign   = ~rst & (state_q == S_IDLE) & acc & misaligned;
  assign dm_req         = (state_q == S_REQ);
  assign dm_we          = dm_we_q;
  assign dm_addr        = dm_addr_q;
  assign dm_be          = dm_be_q;
  assign dm_wdata       = dm_wdata_q;
  assign mem_load_data  = load_data_q;
  assign mem_load_valid = load_valid_q;
  assign bus_err        = bus_err_q;

endmodule
